// File: rtl/p3p_pkg.sv
// rtl/p3p_pkg.sv - shared datapath types and SRAM arbiter constants
package p3p_pkg;

    // Signed sample word shared by gdp_controller, normaliser and send
    typedef logic signed [15:0] num;

    // SRAM word address
    typedef logic [20:0] addr_t;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Requester slots on the arbiter
    localparam int REQ_GDP  = 0;
    localparam int REQ_NORM = 1;
    localparam int REQ_SEND = 2;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_cand;

    // Scan upward from the slot after the last winner, wrapping, first hit wins
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_cand   = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDX_W'((int'(i_last) + k) % N);
            if (!o_any && i_req[w_cand]) begin
                o_any            = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin request/grant scheduler in front of the SRAM unit
module sram_arbiter
    import p3p_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 21,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*16-1:0]     req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic [15:0]             rdata,
    input  logic                    sram_idle,
    input  logic                    sram_ready,
    input  logic [15:0]             sram_rdata,
    output logic                    read_sram,
    output logic                    write_sram,
    output logic [ADDR_W-1:0]       sram_addr_o,
    output logic [15:0]             sram_wdata_o,
    output logic                    busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic [IDX_W-1:0]   r_last_gnt;
    logic               r_we;
    logic [CNT_W-1:0]   r_cnt;

    logic [N_REQ-1:0]   w_pick_onehot;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_latch;
    logic               w_finish;
    logic               w_timeout;
    logic [ADDR_W-1:0]  w_sel_addr;
    num                 w_sel_wdata;
    logic               w_sel_we;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req    (req),
        .i_last   (r_last_gnt),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_sel_addr  = req_addr[w_pick_idx*ADDR_W +: ADDR_W];
    assign w_sel_wdata = req_wdata[w_pick_idx*16 +: 16];
    assign w_sel_we    = req_we[w_pick_idx];
    assign busy        = (r_state != IDLE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; sram_ready is only honoured in WAIT, and beats a same-cycle timeout
    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_finish  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any && sram_idle) begin
                    w_latch = 1'b1;
                    w_next  = ISSUE;
                end
            end
            ISSUE: begin
                w_next = WAIT;
            end
            WAIT: begin
                if (sram_ready) begin
                    w_finish = 1'b1;
                    w_next   = DONE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_finish  = 1'b1;
                    w_timeout = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Latch the winner's command and raise its strobe so it is visible during ISSUE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_gnt   <= IDX_W'(N_REQ - 1);
            r_we         <= 1'b0;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
            read_sram    <= 1'b0;
            write_sram   <= 1'b0;
        end else begin
            read_sram  <= 1'b0;
            write_sram <= 1'b0;
            if (w_latch) begin
                r_last_gnt   <= w_pick_idx;
                r_we         <= w_sel_we;
                sram_addr_o  <= w_sel_addr;
                sram_wdata_o <= w_sel_wdata;
                read_sram    <= ~w_sel_we;
                write_sram   <= w_sel_we;
            end
        end
    end

    // Cycles since the strobe: zero during ISSUE, so the abort lands TIMEOUT cycles after it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_latch) begin
            r_cnt <= '0;
        end else if ((r_state == ISSUE) || (r_state == WAIT && !w_finish)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Grant lifetime, completion/error pulses and read data capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt   <= '0;
            done  <= '0;
            err   <= '0;
            rdata <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            if (w_latch) begin
                gnt <= w_pick_onehot;
            end else if (r_state == DONE) begin
                gnt <= '0;
            end
            if (w_finish) begin
                done <= gnt;
                err  <= w_timeout ? gnt : '0;
                if (!w_timeout && !r_we) begin
                    rdata <= sram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

    localparam int N_REQ   = 3;
    localparam int ADDR_W  = 21;
    localparam int TIMEOUT = 64;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*16-1:0]     req_wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic [N_REQ-1:0]        err;
    logic [15:0]             rdata;
    logic                    sram_idle;
    logic                    sram_ready;
    logic [15:0]             sram_rdata;
    logic                    read_sram;
    logic                    write_sram;
    logic [ADDR_W-1:0]       sram_addr_o;
    logic [15:0]             sram_wdata_o;
    logic                    busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    sram_arbiter #(
        .N_REQ   (N_REQ),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .sram_idle    (sram_idle),
        .sram_ready   (sram_ready),
        .sram_rdata   (sram_rdata),
        .read_sram    (read_sram),
        .write_sram   (write_sram),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // SRAM model: latency 2, ready pulses the cycle after the strobe; no_ready suppresses it
    logic [15:0] mem [0:255];
    logic        no_ready;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_ready <= 1'b0;
            sram_rdata <= 16'h0;
        end else begin
            sram_ready <= 1'b0;
            if ((read_sram || write_sram) && !no_ready) begin
                sram_ready <= 1'b1;
                if (write_sram) mem[sram_addr_o[7:0]] <= sram_wdata_o;
                else            sram_rdata <= mem[sram_addr_o[7:0]];
            end
        end
    end

    // Completion order recorder and one-hot watch
    int   order_q[$];
    logic rec_en = 1'b0;
    int   onehot_bad = 0;

    always @(negedge clk) begin
        if (rec_en && done != '0)
            order_q.push_back(done == 3'b001 ? 0 : (done == 3'b010 ? 1 : 2));
        if (!$onehot0(gnt) || !$onehot0(done)) onehot_bad++;
    end

    task automatic drive(input int i, input logic on, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [15:0] d);
        req[i]                    = on;
        req_we[i]                 = we;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*16 +: 16]     = d;
    endtask

    task automatic wait_done(input int i, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[i] && n < limit);
        check($sformatf("done%0d_seen", i), {31'b0, done[i]}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        sram_idle = 1'b1; no_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", {29'b0, gnt}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_strobes", {30'b0, read_sram, write_sram}, 0);
        check("rst_done_err", {26'b0, done, err}, 0);
        check("rst_data", {rdata, sram_wdata_o}, 0);
        check("rst_addr", {11'b0, sram_addr_o}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single write
        drive(0, 1'b1, 1'b1, 21'h00004, 16'h8F3A);
        @(negedge clk);
        check("t1_gnt", {29'b0, gnt}, 3'b001);
        check("t1_wr", {30'b0, read_sram, write_sram}, 2'b01);
        check("t1_addr", {11'b0, sram_addr_o}, 32'h4);
        check("t1_wdata", {16'b0, sram_wdata_o}, 32'h8F3A);
        check("t1_busy", {31'b0, busy}, 1);
        @(negedge clk);
        check("t1_wr_once", {30'b0, read_sram, write_sram}, 0);
        check("t1_no_early_done", {29'b0, done}, 0);
        @(negedge clk);
        check("t1_done", {29'b0, done}, 3'b001);
        check("t1_err", {29'b0, err}, 0);
        check("t1_gnt_in_done", {29'b0, gnt}, 3'b001);
        drive(0, 1'b0, 1'b1, 21'h00004, 16'h8F3A);
        @(negedge clk);
        check("t1_idle", {25'b0, gnt, done, busy}, 0);

        // Read-back by the sender
        drive(2, 1'b1, 1'b0, 21'h00004, 16'h0);
        wait_done(2, 20, cyc);
        check("t2_latency", cyc, 3);
        check("t2_done", {29'b0, done}, 3'b100);
        check("t2_rdata", {16'b0, rdata}, 32'h8F3A);
        drive(2, 1'b0, 1'b0, 21'h00004, 16'h0);
        repeat (3) @(negedge clk);
        check("t2_rdata_hold", {16'b0, rdata}, 32'h8F3A);

        // Contention from reset
        reset = 1'b1;
        for (int i = 0; i < N_REQ; i++)
            drive(i, 1'b1, 1'b1, 21'h10 + 21'(i), 16'h1000 + 16'(i));
        @(negedge clk);
        reset = 1'b0;
        order_q.delete();
        onehot_bad = 0;
        rec_en = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (order_q.size() >= 6) break;
        end
        req = '0;
        rec_en = 1'b0;
        check("t3_count", order_q.size(), 6);
        for (int k = 0; k < 6; k++)
            check($sformatf("t3_order%0d", k), (k < order_q.size()) ? order_q[k] : -1, k % 3);
        check("t3_onehot", onehot_bad, 0);
        @(negedge clk);

        // SRAM busy holds off the grant
        sram_idle = 1'b0;
        drive(1, 1'b1, 1'b0, 21'h11, 16'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("t4_hold%0d", c), {27'b0, gnt, read_sram, write_sram}, 0);
        end
        sram_idle = 1'b1;
        @(negedge clk);
        check("t4_gnt", {29'b0, gnt}, 3'b010);
        check("t4_rd", {30'b0, read_sram, write_sram}, 2'b10);
        wait_done(1, 20, cyc);
        check("t4_latency", cyc, 2);
        check("t4_rdata", {16'b0, rdata}, 32'h1001);
        drive(1, 1'b0, 1'b0, 21'h11, 16'h0);
        @(negedge clk);

        // Timeout on a read from the normaliser
        no_ready = 1'b1;
        drive(1, 1'b1, 1'b0, 21'h00004, 16'h0);
        @(negedge clk);
        check("t5_strobe", {31'b0, read_sram}, 1);
        wait_done(1, 200, cyc);
        check("t5_tmo_latency", cyc, TIMEOUT);
        check("t5_err", {29'b0, err}, 3'b010);
        check("t5_rdata_kept", {16'b0, rdata}, 32'h1001);
        drive(1, 1'b0, 1'b0, 21'h00004, 16'h0);
        no_ready = 1'b0;
        @(negedge clk);
        check("t5_err_pulse", {29'b0, err}, 0);
        drive(0, 1'b1, 1'b0, 21'h00004, 16'h0);
        wait_done(0, 20, cyc);
        check("t5_next_latency", cyc, 3);
        check("t5_next_err", {29'b0, err}, 0);
        check("t5_next_rdata", {16'b0, rdata}, 32'h8F3A);
        drive(0, 1'b0, 1'b0, 21'h00004, 16'h0);
        @(negedge clk);

        // Reset while waiting on the SRAM
        no_ready = 1'b1;
        drive(0, 1'b1, 1'b1, 21'h20, 16'h5555);
        repeat (4) @(negedge clk);
        check("t6_busy_pre", {31'b0, busy}, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_gnt", {29'b0, gnt}, 0);
        check("t6_rst_busy", {31'b0, busy}, 0);
        check("t6_rst_strobes_done", {27'b0, done, read_sram, write_sram}, 0);
        drive(0, 1'b1, 1'b0, 21'h00004, 16'h0);
        drive(2, 1'b1, 1'b0, 21'h00004, 16'h0);
        no_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t6_first_gnt", {29'b0, gnt}, 3'b001);
        wait_done(0, 20, cyc);
        drive(0, 1'b0, 1'b0, 21'h00004, 16'h0);
        wait_done(2, 20, cyc);
        check("t6_second_done", {29'b0, done}, 3'b100);
        check("t6_rdata", {16'b0, rdata}, 32'h8F3A);
        drive(2, 1'b0, 1'b0, 21'h00004, 16'h0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
